// File: rtl/glb_core_pcfg_dma.sv
// glb_core_pcfg_dma: parallel-config read sequencer that streams bank reads into CGRA config writes
// Ports:
//   clk, reset_n                 tile clock, asynchronous active-low reset
//   cfg_start_addr, cfg_num_words first byte address and word count, sampled on an accepted start
//   pcfg_start_pulse             one-cycle start request, honoured only while idle
//   rdrq_rd_en, rdrq_rd_addr     bank read request (registered)
//   rdrs_rd_data(_valid)         bank read response
//   cgra_cfg_wr/_addr/_data      configuration write unpacked from each response (registered)
//   pcfg_busy, pcfg_done_pulse   run in progress, one-cycle completion interrupt
//   pcfg_err_spurious            sticky flag for responses that arrive with nothing outstanding
module glb_core_pcfg_dma #(
    parameter int GLB_ADDR_WIDTH      = 19,
    parameter int BANK_DATA_WIDTH     = 64,
    parameter int CGRA_CFG_ADDR_WIDTH = 32,
    parameter int CGRA_CFG_DATA_WIDTH = 32,
    parameter int MAX_OUTSTANDING     = 8,
    parameter int NUM_WORDS_WIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [GLB_ADDR_WIDTH-1:0]      cfg_start_addr,
    input  logic [NUM_WORDS_WIDTH-1:0]     cfg_num_words,
    input  logic                           pcfg_start_pulse,
    output logic                           rdrq_rd_en,
    output logic [GLB_ADDR_WIDTH-1:0]      rdrq_rd_addr,
    input  logic [BANK_DATA_WIDTH-1:0]     rdrs_rd_data,
    input  logic                           rdrs_rd_data_valid,
    output logic                           cgra_cfg_wr,
    output logic [CGRA_CFG_ADDR_WIDTH-1:0] cgra_cfg_addr,
    output logic [CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_data,
    output logic                           pcfg_busy,
    output logic                           pcfg_done_pulse,
    output logic                           pcfg_err_spurious
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
    localparam logic [GLB_ADDR_WIDTH-1:0] STRIDE = GLB_ADDR_WIDTH'(BANK_DATA_WIDTH / 8);
    localparam logic [NUM_WORDS_WIDTH-1:0] ONE = NUM_WORDS_WIDTH'(1);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t                     state;
    logic [GLB_ADDR_WIDTH-1:0]  addr;
    logic [NUM_WORDS_WIDTH-1:0] req_rem;
    logic [NUM_WORDS_WIDTH-1:0] rsp_rem;
    logic [OW-1:0]              outst;
    logic                       rsp_ok;
    logic                       slot_free;
    // outst counts requests whose request cycle has completed; the request on the
    // wire this cycle still occupies a slot, while a same-cycle response frees one only next cycle
    assign rsp_ok    = rdrs_rd_data_valid && (outst != '0);
    assign slot_free = (outst + OW'(rdrq_rd_en)) < MAX_OS;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            addr              <= '0;
            req_rem           <= '0;
            rsp_rem           <= '0;
            outst             <= '0;
            rdrq_rd_en        <= 1'b0;
            rdrq_rd_addr      <= '0;
            cgra_cfg_wr       <= 1'b0;
            cgra_cfg_addr     <= '0;
            cgra_cfg_data     <= '0;
            pcfg_busy         <= 1'b0;
            pcfg_done_pulse   <= 1'b0;
            pcfg_err_spurious <= 1'b0;
        end else begin
            rdrq_rd_en      <= 1'b0;
            pcfg_done_pulse <= 1'b0;
            cgra_cfg_wr     <= rsp_ok;
            outst           <= outst + OW'(rdrq_rd_en) - OW'(rsp_ok);
            case (state)
                IDLE: if (pcfg_start_pulse) begin
                    pcfg_busy         <= 1'b1;
                    pcfg_err_spurious <= 1'b0;
                    if (cfg_num_words == '0) begin
                        state           <= DONE;
                        pcfg_done_pulse <= 1'b1;
                    end else begin
                        // the first request goes out with the start so it appears one cycle later
                        rdrq_rd_en   <= 1'b1;
                        rdrq_rd_addr <= cfg_start_addr;
                        addr         <= cfg_start_addr + STRIDE;
                        req_rem      <= cfg_num_words - ONE;
                        rsp_rem      <= cfg_num_words;
                        state        <= (cfg_num_words == ONE) ? DRAIN : REQ;
                    end
                end
                REQ: if (slot_free) begin
                    rdrq_rd_en   <= 1'b1;
                    rdrq_rd_addr <= addr;
                    addr         <= addr + STRIDE;
                    req_rem      <= req_rem - ONE;
                    if (req_rem == ONE) state <= DRAIN;
                end
                DRAIN: if (rsp_rem == '0) begin
                    state           <= DONE;
                    pcfg_done_pulse <= 1'b1;
                end
                DONE: begin
                    pcfg_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (rsp_ok) begin
                cgra_cfg_addr <= rdrs_rd_data[BANK_DATA_WIDTH-1 -: CGRA_CFG_ADDR_WIDTH];
                cgra_cfg_data <= rdrs_rd_data[CGRA_CFG_DATA_WIDTH-1:0];
                rsp_rem       <= rsp_rem - ONE;
            end else if (rdrs_rd_data_valid) begin
                pcfg_err_spurious <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_glb_core_pcfg_dma.sv
// tb_glb_core_pcfg_dma: directed scoreboard bench for glb_core_pcfg_dma
module tb_glb_core_pcfg_dma;
    localparam int AW = 19;
    localparam int DW = 64;
    localparam int MO = 8;
    localparam int NW = 16;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cfg_start_addr = '0;
    logic [NW-1:0] cfg_num_words = '0;
    logic          pcfg_start_pulse = 1'b0;
    logic          rdrq_rd_en;
    logic [AW-1:0] rdrq_rd_addr;
    logic [DW-1:0] rdrs_rd_data = '0;
    logic          rdrs_rd_data_valid = 1'b0;
    logic          cgra_cfg_wr;
    logic [31:0]   cgra_cfg_addr;
    logic [31:0]   cgra_cfg_data;
    logic          pcfg_busy;
    logic          pcfg_done_pulse;
    logic          pcfg_err_spurious;

    always #5 clk = ~clk;

    glb_core_pcfg_dma dut (
        .clk(clk), .reset_n(reset_n), .cfg_start_addr(cfg_start_addr), .cfg_num_words(cfg_num_words),
        .pcfg_start_pulse(pcfg_start_pulse), .rdrq_rd_en(rdrq_rd_en), .rdrq_rd_addr(rdrq_rd_addr),
        .rdrs_rd_data(rdrs_rd_data), .rdrs_rd_data_valid(rdrs_rd_data_valid), .cgra_cfg_wr(cgra_cfg_wr),
        .cgra_cfg_addr(cgra_cfg_addr), .cgra_cfg_data(cgra_cfg_data), .pcfg_busy(pcfg_busy),
        .pcfg_done_pulse(pcfg_done_pulse), .pcfg_err_spurious(pcfg_err_spurious)
    );

    typedef struct {int due; logic [AW-1:0] a;} rsp_t;
    typedef struct {int due; logic [31:0] a; logic [31:0] d;} wr_t;
    rsp_t          rq[$];
    wr_t           wq[$];
    logic [AW-1:0] aq[$];
    int npass = 0, ntot = 0, nfail = 0, cyc = 0, lat = 3;
    int mdl_out = 0, max_out = 0, wr_cnt = 0, last_wr = 0, rd_cnt = 0, first_rd = 0, last_rd = 0;
    bit inj = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem(logic [AW-1:0] a);
        return {32'hC0DE_0000 ^ 32'(a), 32'h0BAD_0000 + ~32'(a)};
    endfunction

    // one clock: observe DUT at the falling edge, score it, then drive the memory response
    task automatic tick;
        bit   exp_wr;
        wr_t  w;
        rsp_t r;
        @(negedge clk);
        cyc++;
        rdrs_rd_data_valid = 1'b0;
        if (!reset_n) begin
            aq.delete();
            wq.delete();
            mdl_out = 0;
        end else begin
            if (rdrq_rd_en) begin
                if (aq.size() == 0) chk("rd_extra", rdrq_rd_en, 0);
                else chk("rd_addr", rdrq_rd_addr, aq.pop_front());
                rd_cnt++;
                if (rd_cnt == 1) first_rd = cyc;
                last_rd = cyc;
            end
            exp_wr = wq.size() > 0 && wq[0].due == cyc;
            chk("cfg_wr", cgra_cfg_wr, exp_wr);
            if (exp_wr) begin
                w = wq.pop_front();
                if (cgra_cfg_wr) begin
                    chk("cfg_addr", cgra_cfg_addr, w.a);
                    chk("cfg_data", cgra_cfg_data, w.d);
                    wr_cnt++;
                    last_wr = cyc;
                end
            end
        end
        if (rdrq_rd_en) rq.push_back('{cyc + lat, rdrq_rd_addr});
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            rdrs_rd_data = mem(r.a);
            rdrs_rd_data_valid = 1'b1;
        end else if (inj) begin
            inj = 0;
            rdrs_rd_data = mem(AW'('h1234));
            rdrs_rd_data_valid = 1'b1;
        end
        if (rdrs_rd_data_valid && reset_n && mdl_out > 0) begin
            wq.push_back('{cyc + 1, rdrs_rd_data[63:32], rdrs_rd_data[31:0]});
            mdl_out--;
        end
        if (rdrq_rd_en && reset_n) mdl_out++;
        if (mdl_out > max_out) max_out = mdl_out;
    endtask

    task automatic run(logic [AW-1:0] a, int n, int l, bit mid);
        int exp_max;
        lat = l;
        max_out = 0;
        wr_cnt = 0;
        rd_cnt = 0;
        last_wr = 0;
        exp_max = (l < n) ? l : n;
        if (exp_max > MO) exp_max = MO;
        for (int i = 0; i < n; i++) aq.push_back(AW'(a + 8 * i));
        cfg_start_addr = a;
        cfg_num_words = NW'(n);
        pcfg_start_pulse = 1'b1;
        tick;
        pcfg_start_pulse = 1'b0;
        chk("busy_t1", pcfg_busy, 1);
        chk("rd_en_t1", rdrq_rd_en, n > 0);
        chk("err_clear_on_start", pcfg_err_spurious, 0);
        if (n == 0) begin
            chk("done_zero_t1", pcfg_done_pulse, 1);
        end else begin
            for (int k = 0; k < 3000; k++) begin
                if (mid && k == 2) begin
                    cfg_start_addr = AW'('h5000);
                    cfg_num_words = NW'(7);
                end
                pcfg_start_pulse = mid && k == 2;
                tick;
                pcfg_start_pulse = 1'b0;
                if (pcfg_done_pulse) break;
            end
            chk("done_seen", pcfg_done_pulse, 1);
            chk("done_after_last_wr", cyc, last_wr + 1);
            chk("busy_at_done", pcfg_busy, 1);
            chk("rd_consecutive", last_rd - first_rd == n - 1, l <= MO);
        end
        chk("wr_count", wr_cnt, n);
        chk("rd_count", rd_cnt, n);
        chk("max_outstanding", max_out, exp_max);
        tick;
        chk("busy_drop", pcfg_busy, 0);
        chk("done_one_cycle", pcfg_done_pulse, 0);
        chk("addr_queue_empty", aq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_rd_en"}, rdrq_rd_en, 0);
        chk({tag, "_rd_addr"}, rdrq_rd_addr, 0);
        chk({tag, "_cfg_wr"}, cgra_cfg_wr, 0);
        chk({tag, "_cfg_addr"}, cgra_cfg_addr, 0);
        chk({tag, "_cfg_data"}, cgra_cfg_data, 0);
        chk({tag, "_busy"}, pcfg_busy, 0);
        chk({tag, "_done"}, pcfg_done_pulse, 0);
        chk({tag, "_err"}, pcfg_err_spurious, 0);
    endtask

    initial begin
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        chk_reset_outputs("reset");
        run(AW'('h100), 4, 3, 0);
        run(AW'('h0), 20, 12, 0);
        run(AW'((1 << AW) - 8), 2, 3, 0);
        run(AW'('h40), 0, 3, 0);
        run(AW'('h300), 6, 1, 1);
        tick;
        inj = 1;
        tick;
        tick;
        chk("spurious_set", pcfg_err_spurious, 1);
        tick;
        chk("spurious_sticky", pcfg_err_spurious, 1);
        run(AW'('h400), 3, 2, 0);
        lat = 3;
        for (int i = 0; i < 10; i++) aq.push_back(AW'('h800 + 8 * i));
        cfg_start_addr = AW'('h800);
        cfg_num_words = NW'(10);
        pcfg_start_pulse = 1'b1;
        tick;
        pcfg_start_pulse = 1'b0;
        repeat (4) tick;
        chk("midrun_busy", pcfg_busy, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        tick;
        reset_n = 1'b1;
        repeat (8) tick;
        chk("post_reset_spurious", pcfg_err_spurious, 1);
        chk("post_reset_idle", pcfg_busy, 0);
        run(AW'('h200), 5, 2, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
